ultrasound_scheduler: RTL
=========================

Name: ultrasound_scheduler

Overview:
- Round-robin sequencer for the four ultrasonic range sensors. Only one sensor is fired at a time, so echoes cannot cross-talk.
- Per slot: generate the trigger pulse, time the echo pulse in microseconds, post the result, then wait out a guard interval before moving to the next enabled sensor.
- Sits between the sensor pins (trig/echo) and the Avalon-facing register bank that the NIOS reads for theremin pitch/volume.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency; µs prescaler DIV = CLK_FREQ_HZ/1000000.
- N_SENSORS, 4, number of sensors; index width IDXW = clog2(N_SENSORS).
- TRIG_US, 10, trigger pulse width in µs.
- TIMEOUT_US, 30000, maximum wait for echo rise, and maximum echo high time.
- GUARD_US, 10000, quiet time after each slot before the next trigger.
- CNT_W, 16, width of the measurement counter and result.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- run  in  1  1 = keep cycling through sensors; 0 = stop after the current slot
- enable_mask  in  N_SENSORS  per-sensor enable
- echo  in  N_SENSORS  raw echo inputs (asynchronous)
- trig  out  N_SENSORS  trigger outputs, at most one bit high
- meas_valid  out  1  one-cycle strobe, result posted
- meas_idx  out  IDXW  sensor index of the posted result
- meas_us  out  CNT_W  echo width in µs
- meas_timeout  out  1  posted result is a timeout
- dist_flat  out  N_SENSORS*CNT_W  latest result per sensor; sensor i occupies bits [i*CNT_W +: CNT_W]
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: asynchronous, active-low. Every output 0, state IDLE, cur_idx = N_SENSORS-1 (so sensor 0 is fired first), echo synchronizers 0.
- Echo sync: each bit passes through a 2-flop synchronizer, plus a third flop for edge detection. Rise/fall are detected 3 cycles after the pin changes.
- Timebase: prescaler produces us_tick once every DIV cycles. Prescaler and µs counter both clear on every state entry, so all durations are exact multiples of DIV cycles.
- Next-sensor select: first set bit of enable_mask strictly after cur_idx, wrapping modulo N_SENSORS. enable_mask is sampled only at selection time.
- IDLE: if run=1 and enable_mask != 0, select the next sensor and go to TRIG. Otherwise remain in IDLE.
- TRIG: trig[cur_idx] = 1 for exactly TRIG_US*DIV cycles, then go to WAIT_RISE.
- WAIT_RISE:
  - Synchronized rising edge → MEASURE, counter cleared.
  - Counter reaches TIMEOUT_US → post timeout, go to GUARD.
  - An echo that is already high on entry does not count; only a rising edge starts measurement.
- MEASURE: counter increments on each us_tick.
  - Falling edge → post the counter value, go to GUARD.
  - Counter reaches TIMEOUT_US → post timeout, go to GUARD.
- Posting:
  - Occurs on the cycle after the edge or timeout is detected.
  - meas_valid pulses high for 1 cycle.
  - meas_idx = cur_idx.
  - meas_us = width, or all-ones on timeout.
  - meas_timeout set accordingly.
  - dist_flat slice for cur_idx updated to the same value.
  - meas_us, meas_idx and meas_timeout hold their values until the next post.
- Width rule: meas_us saturates at 2^CNT_W-1. TIMEOUT_US must be less than 2^CNT_W; this is checked by an elaboration assertion.
- GUARD: wait GUARD_US. Then, if run=1 and the mask is non-zero, select the next sensor and go to TRIG; otherwise go to IDLE.
- run deasserted mid-slot: the current slot completes, including its post and guard, then IDLE. A trigger is never truncated.
- Single enabled sensor: that sensor is re-fired every slot.
- Mask bit cleared for the sensor in flight: the slot completes normally.
- Echo activity on sensors other than cur_idx is ignored.

Decomposition:
- Package ultrasound_pkg:
  - state enum (IDLE, TRIG, WAIT_RISE, MEASURE, GUARD)
  - helper function computing DIV and the cycle counts
  - function next_idx(mask, cur)
- Sub-module us_timebase: prescaler with synchronous clear, outputs us_tick.
- The echo synchronizer stays inline.

Test Plan (CLK_FREQ_HZ=1000000, so DIV=1; TIMEOUT_US=300; GUARD_US=20):
- Mask=4'b1111, run=1; sensor 0 echo rises 5 µs after trig falls and is held 120 µs → trig[0] high exactly 10 cycles; post meas_idx=0, meas_us=120, meas_timeout=0; dist_flat[15:0]=120; next trigger on trig[1] after the 20 µs guard.
- Mask=4'b1010 → firing order 1,3,1,3; trig[0] and trig[2] never assert.
- Sensor 2 echo never rises → after 300 µs, post meas_idx=2, meas_us=16'hFFFF, meas_timeout=1; scheduler continues to sensor 3.
- Echo held high from before the trigger (stuck high) → timeout post (16'hFFFF). Separately, echo high longer than 300 µs → timeout post, never a wrapped value.
- run dropped mid-MEASURE → the echo width is still posted, guard completes, then IDLE with busy=0; raising run again fires the next sensor in round-robin order.
- reset_reset_n asserted during TRIG → trig=0, outputs zero immediately and asynchronously; after release, the first trigger goes to sensor 0.

Source files
------------

// File: rtl/ultrasound_pkg.sv
// Shared state encodings and timing helpers for the ultrasonic sensor scheduler.
package ultrasound_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_TRIG      = 3'd1;
    localparam state_t ST_WAIT_RISE = 3'd2;
    localparam state_t ST_MEASURE   = 3'd3;
    localparam state_t ST_GUARD     = 3'd4;

    // Clock cycles per microsecond, never below one.
    function automatic int unsigned us_div(input int unsigned clk_hz);
        return (clk_hz / 1000000 == 0) ? 1 : clk_hz / 1000000;
    endfunction

    function automatic int unsigned us_cycles(input int unsigned clk_hz, input int unsigned us);
        return us * us_div(clk_hz);
    endfunction

    // First enabled sensor strictly after cur, wrapping; returns cur when nothing is enabled.
    function automatic int unsigned next_idx(input logic [31:0] mask, input int unsigned cur,
                                             input int unsigned n);
        int unsigned sel;
        int unsigned idx;
        logic        found;
        sel   = cur;
        found = 1'b0;
        for (int unsigned i = 1; i <= n; i++) begin
            idx = (cur + i) % n;
            if (!found && ((mask >> idx) & 32'd1) != 32'd0) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/ultrasound_scheduler_timebase.sv
// Microsecond prescaler: us_tick every DIV cycles, restartable so durations align to state entry.
module us_timebase #(
    parameter int unsigned DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic us_tick
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre;

    assign us_tick = (pre == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (clr || us_tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

endmodule

// File: rtl/ultrasound_scheduler.sv
// Round-robin trigger/echo sequencer for the ultrasonic range sensors.
// One sensor in flight at a time; each result is strobed out and kept in a per-sensor bank.
module ultrasound_scheduler
    import ultrasound_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned N_SENSORS   = 4,
    parameter int unsigned TRIG_US     = 10,
    parameter int unsigned TIMEOUT_US  = 30000,
    parameter int unsigned GUARD_US    = 10000,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned IDXW       = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic                         run,
    input  logic [N_SENSORS-1:0]         enable_mask,
    input  logic [N_SENSORS-1:0]         echo,
    output logic [N_SENSORS-1:0]         trig,
    output logic                         meas_valid,
    output logic [IDXW-1:0]              meas_idx,
    output logic [CNT_W-1:0]             meas_us,
    output logic                         meas_timeout,
    output logic [N_SENSORS*CNT_W-1:0]   dist_flat,
    output logic                         busy
);

    localparam int unsigned DIV     = us_div(CLK_FREQ_HZ);
    localparam logic [32:0] CNT_MAX = (33'd1 << CNT_W) - 33'd1;

    if (TIMEOUT_US >= (64'd1 << CNT_W)) begin : g_timeout_range
        $error("TIMEOUT_US must be below 2**CNT_W");
    end

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   cur_idx;
    logic [IDXW-1:0]   sel_idx;
    logic              select;
    logic              post;
    logic              post_to;
    logic [CNT_W-1:0]  post_val;
    logic [32:0]       width_raw;
    logic              clr;
    logic              us_tick;
    logic [31:0]       us_cnt;
    logic [31:0]       cnt_lim;
    logic              cnt_hit;

    logic [N_SENSORS-1:0] echo_s1;
    logic [N_SENSORS-1:0] echo_s2;
    logic [N_SENSORS-1:0] echo_s3;
    logic                 echo_rise;
    logic                 echo_fall;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
            echo_s3 <= '0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_s3 <= echo_s2;
        end
    end

    assign echo_rise = echo_s2[cur_idx] & ~echo_s3[cur_idx];
    assign echo_fall = ~echo_s2[cur_idx] & echo_s3[cur_idx];

    us_timebase #(
        .DIV(DIV)
    ) u_timebase (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .clr    (clr),
        .us_tick(us_tick)
    );

    // cnt_hit marks the tick that completes the current state's programmed duration.
    always_comb begin
        cnt_lim = '0;
        case (state)
            ST_TRIG:                  cnt_lim = 32'(TRIG_US - 1);
            ST_WAIT_RISE, ST_MEASURE: cnt_lim = 32'(TIMEOUT_US - 1);
            ST_GUARD:                 cnt_lim = 32'(GUARD_US - 1);
            default:                  cnt_lim = '0;
        endcase
        cnt_hit = us_tick && (us_cnt == cnt_lim);
    end

    always_comb begin
        state_nxt = state;
        select    = 1'b0;
        post      = 1'b0;
        post_to   = 1'b0;
        sel_idx   = IDXW'(next_idx(32'(enable_mask), 32'(cur_idx), N_SENSORS));
        case (state)
            ST_IDLE: begin
                if (run && |enable_mask) begin
                    state_nxt = ST_TRIG;
                    select    = 1'b1;
                end
            end
            ST_TRIG: begin
                if (cnt_hit) state_nxt = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_nxt = ST_MEASURE;
                end else if (cnt_hit) begin
                    state_nxt = ST_GUARD;
                    post      = 1'b1;
                    post_to   = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (echo_fall) begin
                    state_nxt = ST_GUARD;
                    post      = 1'b1;
                end else if (cnt_hit) begin
                    state_nxt = ST_GUARD;
                    post      = 1'b1;
                    post_to   = 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt_hit) begin
                    if (run && |enable_mask) begin
                        state_nxt = ST_TRIG;
                        select    = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        clr = (state_nxt != state);
    end

    // The tick landing on the fall cycle is part of the pulse, so count it in the posted width.
    always_comb begin
        width_raw = {1'b0, us_cnt} + {32'd0, us_tick};
        if (post_to || width_raw > CNT_MAX) begin
            post_val = '1;
        end else begin
            post_val = width_raw[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state   <= ST_IDLE;
            cur_idx <= IDXW'(N_SENSORS - 1);
            us_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (select) cur_idx <= sel_idx;
            if (clr) begin
                us_cnt <= '0;
            end else if (us_tick && state != ST_IDLE) begin
                us_cnt <= us_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            meas_valid   <= 1'b0;
            meas_idx     <= '0;
            meas_us      <= '0;
            meas_timeout <= 1'b0;
            dist_flat    <= '0;
        end else begin
            meas_valid <= post;
            if (post) begin
                meas_idx     <= cur_idx;
                meas_us      <= post_val;
                meas_timeout <= post_to;
            end
            for (int unsigned i = 0; i < N_SENSORS; i++) begin
                if (post && cur_idx == IDXW'(i)) dist_flat[i*CNT_W +: CNT_W] <= post_val;
            end
        end
    end

    always_comb begin
        trig = '0;
        if (state == ST_TRIG) trig[cur_idx] = 1'b1;
    end

    assign busy = (state != ST_IDLE);

endmodule
